// File: rtl/framebuffer_write_buffer.sv
// framebuffer_write_buffer: posted-write buffer between the renderer write
// path and the shared framebuffer RAM arbiter. Entries are stored in a FIFO of
// DEPTH-1 slots that feeds a registered head (ramReq/ramAddr/ramData), so the
// total capacity is DEPTH. Optional statistics counters are enabled by
// defining FB_WRITE_STATS_EN.
module framebuffer_write_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inWrite,
  input  logic [15:0] inAddr,
  input  logic [15:0] inData,
  output logic        inOK,
  output logic        ramReq,
  output logic [15:0] ramAddr,
  output logic [15:0] ramData,
  input  logic        ramGrant,
  output logic        busy,
  output logic        overflow,
  input  logic        clearStats,
  output logic [31:0] writeCount,
  output logic [31:0] stallCycles
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int SLOTS = DEPTH - 1;
  localparam int PTR_W = $clog2(SLOTS);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(SLOTS - 1);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             ram_req_q, ram_req_d;
  logic [15:0]      ram_addr_q, ram_addr_d;
  logic [15:0]      ram_data_q, ram_data_d;
  logic             in_ok_q, in_ok_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic [31:0]      mem [SLOTS];
  logic [31:0]      mem_rd;
  logic             accept;
  logic             complete;
  logic             fifo_empty;
  logic             head_free;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  assign mem_rd = mem[rd_ptr_q];

  // Next-state logic: accept/complete bookkeeping and head-register refill.
  always_comb begin
    accept     = inWrite & in_ok_q;
    complete   = ram_req_q & ramGrant;
    fifo_empty = (occ_q == OCC_W'(ram_req_q));
    head_free  = ~ram_req_q | complete;
    push       = 1'b0;
    pop        = 1'b0;
    ram_req_d  = ram_req_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    // When the FIFO is empty a fresh write bypasses straight into the head so
    // it is presented one edge after acceptance; otherwise the oldest stored
    // entry refills the head and the new write joins the FIFO tail.
    if (head_free) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        push       = accept;
        ram_req_d  = 1'b1;
        ram_addr_d = mem_rd[31:16];
        ram_data_d = mem_rd[15:0];
      end else if (accept) begin
        ram_req_d  = 1'b1;
        ram_addr_d = inAddr;
        ram_data_d = inData;
      end else begin
        ram_req_d  = 1'b0;
      end
    end else begin
      push = accept;
    end
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d      = occ_q + OCC_W'(accept) - OCC_W'(complete);
    in_ok_d    = (occ_d < OCC_W'(DEPTH));
    busy_d     = (occ_d != '0);
    overflow_d = overflow_q | (inWrite & ~in_ok_q);
  end

  // Control and head-register state; reset discards every held entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_req_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      in_ok_q    <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_req_q  <= ram_req_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      in_ok_q    <= in_ok_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage, written at the tail; contents need no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= {inAddr, inData};
    end
  end

  assign inOK     = in_ok_q;
  assign ramReq   = ram_req_q;
  assign ramAddr  = ram_addr_q;
  assign ramData  = ram_data_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

`ifdef FB_WRITE_STATS_EN
  logic [31:0] write_count_q, write_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Statistics next-state: clear wins over a same-edge increment.
  always_comb begin
    write_count_d  = write_count_q;
    stall_cycles_d = stall_cycles_q;
    if (clearStats) begin
      write_count_d  = '0;
      stall_cycles_d = '0;
    end else begin
      if (complete) begin
        write_count_d = write_count_q + 32'd1;
      end
      if (ram_req_q && !ramGrant) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
    end
  end

  // Statistics counters, wrapping at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      write_count_q  <= write_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign writeCount  = write_count_q;
  assign stallCycles = stall_cycles_q;
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clearStats;
  assign writeCount  = '0;
  assign stallCycles = '0;
`endif

endmodule

// File: tb/tb_framebuffer_write_buffer.sv
// Scoreboard bench for framebuffer_write_buffer (DEPTH=16). Stimulus pushes
// expected {addr,data} into a queue; a negedge monitor pops and compares on
// every completing RAM write and checks head stability while stalled.
module tb_framebuffer_write_buffer;

`ifdef FB_WRITE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inWrite = 1'b0;
  logic [15:0] inAddr = '0;
  logic [15:0] inData = '0;
  logic        inOK;
  logic        ramReq;
  logic [15:0] ramAddr;
  logic [15:0] ramData;
  logic        ramGrant = 1'b0;
  logic        busy;
  logic        overflow;
  logic        clearStats = 1'b0;
  logic [31:0] writeCount;
  logic [31:0] stallCycles;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned completions = 0;
  logic [31:0] sb [$];

  framebuffer_write_buffer #(.DEPTH(16)) dut (
    .clock(clock), .reset(reset), .inWrite(inWrite), .inAddr(inAddr),
    .inData(inData), .inOK(inOK), .ramReq(ramReq), .ramAddr(ramAddr),
    .ramData(ramData), .ramGrant(ramGrant), .busy(busy), .overflow(overflow),
    .clearStats(clearStats), .writeCount(writeCount), .stallCycles(stallCycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    inWrite = 1'b1;
    inAddr  = a;
    inData  = d;
    if (inOK) sb.push_back({a, d});
    cycle();
    inWrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic wait_idle(input string nm);
    int unsigned n = 0;
    while ((busy || ramReq) && n < 60) begin
      cycle();
      n++;
    end
    chk(nm, {31'd0, busy | ramReq}, 32'd0);
  endtask

  // Monitor: compare completions against the scoreboard, check stall hold.
  initial begin : monitor
    logic        prev_stall;
    logic [15:0] prev_addr;
    logic [15:0] prev_data;
    logic [31:0] exp;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_req", {31'd0, ramReq}, 32'd1);
          chk("hold_addr", {16'd0, ramAddr}, {16'd0, prev_addr});
          chk("hold_data", {16'd0, ramData}, {16'd0, prev_data});
        end
        if (ramReq && ramGrant) begin
          completions++;
          if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", ramAddr, ramData);
          end else begin
            exp = sb.pop_front();
            chk("wr_addr", {16'd0, ramAddr}, {16'd0, exp[31:16]});
            chk("wr_data", {16'd0, ramData}, {16'd0, exp[15:0]});
          end
        end
        prev_stall = ramReq && !ramGrant;
        prev_addr  = ramAddr;
        prev_data  = ramData;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned c0;
    int unsigned lows;
    int unsigned reqs;

    // Reset state
    cycle();
    cycle();
    chk("rst_inok", {31'd0, inOK}, 32'd1);
    chk("rst_req", {31'd0, ramReq}, 32'd0);
    chk("rst_addr", {16'd0, ramAddr}, 32'd0);
    chk("rst_data", {16'd0, ramData}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_wcnt", writeCount, 32'd0);
    chk("rst_stall", stallCycles, 32'd0);
    reset = 1'b0;
    cycle();

    // Single write with grant held high
    ramGrant = 1'b1;
    c0 = completions;
    push(16'h0010, 16'hABCD);
    chk("single_req_hi", {31'd0, ramReq}, 32'd1);
    chk("single_busy_hi", {31'd0, busy}, 32'd1);
    cycle();
    chk("single_req_lo", {31'd0, ramReq}, 32'd0);
    chk("single_busy_lo", {31'd0, busy}, 32'd0);
    chk("single_count", completions - c0, 32'd1);

    // Stall hold for five cycles
    do_reset();
    ramGrant = 1'b0;
    push(16'h1234, 16'h5678);
    repeat (5) cycle();
    chk("stall_addr", {16'd0, ramAddr}, 32'h1234);
    chk("stall_data", {16'd0, ramData}, 32'h5678);
    chk("stall_cycles", stallCycles, STATS ? 32'd5 : 32'd0);
    ramGrant = 1'b1;
    cycle();
    chk("stall_done_busy", {31'd0, busy}, 32'd0);

    // Streaming: one push per cycle for 100 cycles with grant high
    do_reset();
    ramGrant = 1'b1;
    c0 = completions;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (!inOK) lows++;
      push(16'h2000 + 16'(i), 16'hC000 ^ 16'(i * 7));
    end
    wait_idle("stream_idle");
    chk("stream_inok_lows", lows, 32'd0);
    chk("stream_count", completions - c0, 32'd100);
    chk("stream_sb_empty", sb.size(), 32'd0);
    chk("stream_wcnt", writeCount, STATS ? 32'd100 : 32'd0);

    // clearStats on the same edge as a completion
    push(16'h3000, 16'h0BAD);
    clearStats = 1'b1;
    cycle();
    clearStats = 1'b0;
    chk("clear_wcnt", writeCount, 32'd0);
    chk("clear_req_lo", {31'd0, ramReq}, 32'd0);

    // Fill to DEPTH with grant low, then overflow, then drain
    do_reset();
    ramGrant = 1'b0;
    c0 = completions;
    for (int i = 0; i < 16; i++) begin
      push(16'h4000 + 16'(i), 16'h0F00 + 16'(i * 3));
      chk("fill_inok", {31'd0, inOK}, (i < 15) ? 32'd1 : 32'd0);
    end
    push(16'hDEAD, 16'hBEEF);
    chk("fill_ovf", {31'd0, overflow}, 32'd1);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    ramGrant = 1'b1;
    #0;
    chk("full_inok_same_cycle", {31'd0, inOK}, 32'd0);
    cycle();
    chk("full_inok_next_cycle", {31'd0, inOK}, 32'd1);
    wait_idle("fill_drain_idle");
    chk("fill_drain_count", completions - c0, 32'd16);
    chk("fill_sb_empty", sb.size(), 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-operation at occupancy 7
    ramGrant = 1'b0;
    for (int i = 0; i < 7; i++) push(16'h5000 + 16'(i), 16'h7000 + 16'(i));
    c0 = completions;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("mrst_inok", {31'd0, inOK}, 32'd1);
    chk("mrst_req", {31'd0, ramReq}, 32'd0);
    chk("mrst_addr", {16'd0, ramAddr}, 32'd0);
    chk("mrst_data", {16'd0, ramData}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ovf", {31'd0, overflow}, 32'd0);
    chk("mrst_wcnt", writeCount, 32'd0);
    chk("mrst_stall", stallCycles, 32'd0);
    cycle();
    cycle();
    reset = 1'b0;
    ramGrant = 1'b1;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (ramReq) reqs++;
    end
    chk("mrst_no_req", reqs, 32'd0);
    chk("mrst_no_completion", completions - c0, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
